// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU parameters: RoB index width, the no-dependency tag and CDB producer IDs.
package cdb_arbiter_pkg;

  localparam int unsigned RoB_WIDTH = 3;

  // Tag one bit wider than a RoB index, so it can never collide with a real entry.
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    SRC_RS  = 2'd0,
    SRC_LSB = 2'd1,
    SRC_AUX = 2'd2
  } src_id_e;

  function automatic int unsigned rr_next(input int unsigned grant, input int unsigned n);
    return (grant + 1 >= n) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer holding queue for results that lost CDB arbitration.
module cdb_src_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IDX_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_data,
  output logic [IDX_W-1:0] o_head_idx,
  output logic [31:0]      o_head_data,
  output logic             o_not_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [IDX_W+31:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_at_cap;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_at_cap    = (r_count == CntW'(DEPTH));
  assign w_pop_ok    = i_pop && (r_count != '0);
  // A full queue still accepts a push when its head leaves on the same edge.
  assign w_push_ok   = i_push && (!w_at_cap || w_pop_ok);
  assign o_drop      = i_en && !i_flush && i_push && !w_push_ok;
  assign o_not_empty = (r_count != '0);
  assign o_full      = (r_count >= CntW'(DEPTH - 1));
  assign {o_head_idx, o_head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        if (w_push_ok && !w_pop_ok)      r_count <= r_count + CntW'(1);
        else if (!w_push_ok && w_pop_ok) r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en && !i_flush && w_push_ok) r_mem[r_wr_ptr] <= {i_idx, i_data};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one registered broadcast per cycle from
// NUM_SRC producers, with a same-cycle bypass when a producer's queue is empty.
module cdb_arbiter #(
  parameter int unsigned RoB_WIDTH  = cdb_arbiter_pkg::RoB_WIDTH,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_signal,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic [NUM_SRC*RoB_WIDTH-1:0] src_index,
  input  logic [NUM_SRC*32-1:0]        src_data,
  output logic [NUM_SRC-1:0]           src_full,
  output logic                         CDB_update_en,
  output logic [RoB_WIDTH-1:0]         CDB_update_index,
  output logic [31:0]                  CDB_update_data,
  output logic                         overflow_err
);

  import cdb_arbiter_pkg::*;

  localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [RoB_WIDTH-1:0] w_head_idx  [NUM_SRC];
  logic [31:0]          w_head_data [NUM_SRC];
  logic [RoB_WIDTH-1:0] w_cand_idx  [NUM_SRC];
  logic [31:0]          w_cand_data [NUM_SRC];
  logic [NUM_SRC-1:0]   w_head_vld;
  logic [NUM_SRC-1:0]   w_cand_vld;
  logic [NUM_SRC-1:0]   w_won;
  logic [NUM_SRC-1:0]   w_push;
  logic [NUM_SRC-1:0]   w_pop;
  logic [NUM_SRC-1:0]   w_drop;
  logic                 w_grant_vld;
  logic [PtrW-1:0]      w_grant_id;
  logic [PtrW-1:0]      w_scan;

  logic                 r_cdb_en;
  logic [RoB_WIDTH-1:0] r_cdb_idx;
  logic [31:0]          r_cdb_data;
  logic                 r_ovf;
  logic [PtrW-1:0]      r_rr_ptr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // A queued head always outranks the live input so per-source order holds.
    assign w_cand_vld[g]  = w_head_vld[g] || src_en[g];
    assign w_cand_idx[g]  = w_head_vld[g] ? w_head_idx[g] : src_index[g*RoB_WIDTH +: RoB_WIDTH];
    assign w_cand_data[g] = w_head_vld[g] ? w_head_data[g] : src_data[g*32 +: 32];
    assign w_won[g]       = w_grant_vld && (w_grant_id == PtrW'(g));
    assign w_pop[g]       = w_won[g] && w_head_vld[g];
    assign w_push[g]      = src_en[g] && (w_head_vld[g] || !w_won[g]);

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .IDX_W (RoB_WIDTH)
    ) u_fifo (
      .i_clk       (clk_in),
      .i_rst_n     (rst_in),
      .i_en        (rdy_in),
      .i_flush     (flush_signal),
      .i_push      (w_push[g]),
      .i_pop       (w_pop[g]),
      .i_idx       (src_index[g*RoB_WIDTH +: RoB_WIDTH]),
      .i_data      (src_data[g*32 +: 32]),
      .o_head_idx  (w_head_idx[g]),
      .o_head_data (w_head_data[g]),
      .o_not_empty (w_head_vld[g]),
      .o_full      (src_full[g]),
      .o_drop      (w_drop[g])
    );
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_scan      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_scan = PtrW'((32'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_grant_vld && w_cand_vld[w_scan]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_scan;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cdb_en   <= 1'b0;
      r_cdb_idx  <= '0;
      r_cdb_data <= '0;
      r_ovf      <= 1'b0;
      r_rr_ptr   <= '0;
    end else if (rdy_in) begin
      if (flush_signal) begin
        r_cdb_en <= 1'b0;
        r_rr_ptr <= '0;
      end else begin
        r_cdb_en <= w_grant_vld;
        if (w_grant_vld) begin
          r_cdb_idx  <= w_cand_idx[w_grant_id];
          r_cdb_data <= w_cand_data[w_grant_id];
          r_rr_ptr   <= PtrW'(rr_next(32'(w_grant_id), NUM_SRC));
        end
        if (|w_drop) r_ovf <= 1'b1;
      end
    end
  end

  assign CDB_update_en    = r_cdb_en;
  assign CDB_update_index = r_cdb_idx;
  assign CDB_update_data  = r_cdb_data;
  assign overflow_err     = r_ovf;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: each task drives one scenario and checks inline.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned RW = 3;
  localparam int unsigned NS = 3;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rdy_in;
  logic           flush_signal;
  logic [NS-1:0]  src_en;
  logic [NS*RW-1:0] src_index;
  logic [NS*32-1:0] src_data;
  logic [NS-1:0]  src_full;
  logic           CDB_update_en;
  logic [RW-1:0]  CDB_update_index;
  logic [31:0]    CDB_update_data;
  logic           overflow_err;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .RoB_WIDTH  (RW),
    .NUM_SRC    (NS),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_signal     (flush_signal),
    .src_en           (src_en),
    .src_index        (src_index),
    .src_data         (src_data),
    .src_full         (src_full),
    .CDB_update_en    (CDB_update_en),
    .CDB_update_index (CDB_update_index),
    .CDB_update_data  (CDB_update_data),
    .overflow_err     (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    src_en       = '0;
    flush_signal = 1'b0;
  endtask

  task automatic drive(input int s, input int idx, input logic [31:0] d);
    src_en[s]             = 1'b1;
    src_index[s*RW +: RW] = RW'(idx);
    src_data[s*32 +: 32]  = d;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%0b want=0", CDB_update_en); end
    checks++; if (CDB_update_index !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", CDB_update_index); end
    checks++; if (CDB_update_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", CDB_update_data); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b want=0", overflow_err); end
    checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL reset_full got=%b want=000", src_full); end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 3, 32'h0000_00AA);
    checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL single_full_pre got=%b want=000", src_full); end
    tick();
    idle();
    checks++; if (CDB_update_en !== 1'b1) begin errors++; $display("FAIL single_en got=%0b want=1", CDB_update_en); end
    checks++; if (CDB_update_index !== 3'd3) begin errors++; $display("FAIL single_idx got=%0d want=3", CDB_update_index); end
    checks++; if (CDB_update_data !== 32'hAA) begin errors++; $display("FAIL single_data got=%h want=aa", CDB_update_data); end
    checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL single_full got=%b want=000", src_full); end
    tick();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL single_idle_en got=%0b want=0", CDB_update_en); end
    checks++; if (CDB_update_data !== 32'hAA) begin errors++; $display("FAIL single_hold got=%h want=aa", CDB_update_data); end
  endtask

  task automatic test_contention();
    int exp_idx [3] = '{1, 2, 4};
    do_reset();
    drive(0, 1, 32'h101);
    drive(1, 2, 32'h202);
    drive(2, 4, 32'h404);
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      if (k == 0) begin
        checks++; if (src_full !== 3'b110) begin errors++; $display("FAIL cont_full got=%b want=110", src_full); end
      end
      checks++;
      if (CDB_update_en !== 1'b1 || CDB_update_index !== RW'(exp_idx[k]) ||
          CDB_update_data !== 32'(exp_idx[k] * 32'h101)) begin
        errors++;
        $display("FAIL cont_%0d got en=%0b idx=%0d data=%h want en=1 idx=%0d data=%h", k,
                 CDB_update_en, CDB_update_index, CDB_update_data, exp_idx[k], exp_idx[k] * 32'h101);
      end
    end
    // Pointer should be back at source 0.
    drive(0, 6, 32'h606);
    drive(1, 7, 32'h707);
    tick();
    idle();
    checks++; if (CDB_update_index !== 3'd6) begin errors++; $display("FAIL cont_rr0 got=%0d want=6", CDB_update_index); end
    tick();
    checks++; if (CDB_update_index !== 3'd7) begin errors++; $display("FAIL cont_rr1 got=%0d want=7", CDB_update_index); end
  endtask

  task automatic test_fairness();
    int seq_tx [2] = '{0, 0};
    int seq_rx [2] = '{0, 0};
    int issued = 0;
    int got = 0;
    int s;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      src_en = '0;
      for (int p = 0; p < 2; p++) begin
        if (!src_full[p]) begin
          drive(p, p, {8'(p), 24'(seq_tx[p])});
          seq_tx[p]++;
          issued++;
        end
      end
      tick();
      s = cyc % 2;
      checks++;
      if (CDB_update_en !== 1'b1 || CDB_update_data !== {8'(s), 24'(seq_rx[s])}) begin
        errors++;
        $display("FAIL fair_%0d got en=%0b data=%h want en=1 data=%h", cyc, CDB_update_en,
                 CDB_update_data, {8'(s), 24'(seq_rx[s])});
      end
      seq_rx[s]++;
      got++;
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (CDB_update_en === 1'b1) begin
        s = (CDB_update_data[31:24] == 8'd1) ? 1 : 0;
        checks++;
        if (CDB_update_data !== {8'(s), 24'(seq_rx[s])}) begin
          errors++;
          $display("FAIL fair_drain got=%h want=%h", CDB_update_data, {8'(s), 24'(seq_rx[s])});
        end
        seq_rx[s]++;
        got++;
      end
    end
    checks++; if (got != issued) begin errors++; $display("FAIL fair_count got=%0d want=%0d", got, issued); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fair_ovf got=%0b want=0", overflow_err); end
  endtask

  task automatic test_overflow();
    logic        exp_en  [7] = '{1, 1, 1, 1, 1, 1, 0};
    int          exp_idx [7] = '{1, 4, 0, 2, 5, 6, 0};
    logic [31:0] exp_dat [7] = '{32'h10, 32'h20, 32'hAB, 32'h12, 32'h21, 32'h22, 32'h0};
    logic        exp_ovf [7] = '{0, 0, 0, 1, 1, 1, 1};
    int aux;
    aux = int'(SRC_AUX);
    do_reset();
    for (int e = 0; e < 7; e++) begin
      idle();
      case (e)
        0: begin drive(1, 1, 32'h10); drive(aux, 4, 32'h20); end
        1: drive(aux, 5, 32'h21);
        2: begin drive(0, 0, 32'hAB); drive(aux, 6, 32'h22); end
        3: begin drive(1, 2, 32'h12); drive(aux, 7, 32'h23); end
        default: ;
      endcase
      tick();
      checks++;
      if (CDB_update_en !== exp_en[e] ||
          (exp_en[e] && (CDB_update_index !== RW'(exp_idx[e]) || CDB_update_data !== exp_dat[e]))) begin
        errors++;
        $display("FAIL ovf_bcast_%0d got en=%0b idx=%0d data=%h want en=%0b idx=%0d data=%h", e,
                 CDB_update_en, CDB_update_index, CDB_update_data, exp_en[e], exp_idx[e], exp_dat[e]);
      end
      checks++;
      if (overflow_err !== exp_ovf[e]) begin
        errors++;
        $display("FAIL ovf_flag_%0d got=%0b want=%0b", e, overflow_err, exp_ovf[e]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 32'h31);
    tick();
    idle();
    drive(2, 2, 32'h32);
    drive(1, 3, 32'h33);
    tick();
    idle();
    checks++; if (CDB_update_index !== 3'd2) begin errors++; $display("FAIL flush_pre_b got=%0d want=2", CDB_update_index); end
    drive(0, 4, 32'h34);
    drive(1, 6, 32'h36);
    tick();
    idle();
    checks++; if (CDB_update_index !== 3'd4) begin errors++; $display("FAIL flush_pre_c got=%0d want=4", CDB_update_index); end
    checks++; if (src_full !== 3'b010) begin errors++; $display("FAIL flush_queued got=%b want=010", src_full); end
    flush_signal = 1'b1;
    drive(1, 7, 32'h37);
    tick();
    idle();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL flush_en got=%0b want=0", CDB_update_en); end
    checks++; if (src_full !== 3'b000) begin errors++; $display("FAIL flush_full got=%b want=000", src_full); end
    drive(1, 5, 32'h55);
    tick();
    idle();
    checks++;
    if (CDB_update_en !== 1'b1 || CDB_update_index !== 3'd5 || CDB_update_data !== 32'h55) begin
      errors++;
      $display("FAIL flush_after got en=%0b idx=%0d data=%h want en=1 idx=5 data=55", CDB_update_en,
               CDB_update_index, CDB_update_data);
    end
    tick();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL flush_stale got=%0b want=0", CDB_update_en); end
  endtask

  task automatic test_freeze();
    do_reset();
    drive(0, 2, 32'h77);
    tick();
    idle();
    rdy_in = 1'b0;
    drive(1, 3, 32'h99);
    flush_signal = 1'b1;
    tick();
    checks++;
    if (CDB_update_en !== 1'b1 || CDB_update_index !== 3'd2 || CDB_update_data !== 32'h77) begin
      errors++;
      $display("FAIL freeze_hold got en=%0b idx=%0d data=%h want en=1 idx=2 data=77", CDB_update_en,
               CDB_update_index, CDB_update_data);
    end
    rdy_in = 1'b1;
    idle();
    tick();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL freeze_ignored got=%0b want=0", CDB_update_en); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 2, 32'h5A);
    drive(1, 3, 32'h5B);
    tick();
    idle();
    checks++; if (CDB_update_en !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0b want=1", CDB_update_en); end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (CDB_update_en !== 1'b0 || CDB_update_index !== 3'd0 || CDB_update_data !== 32'd0) begin
      errors++;
      $display("FAIL areset_now got en=%0b idx=%0d data=%h want all 0", CDB_update_en,
               CDB_update_index, CDB_update_data);
    end
    #1 rst_in = 1'b1;
    drive(0, 6, 32'h66);
    drive(1, 7, 32'h67);
    tick();
    idle();
    checks++; if (CDB_update_index !== 3'd6) begin errors++; $display("FAIL areset_first got=%0d want=6", CDB_update_index); end
    tick();
    checks++; if (CDB_update_index !== 3'd7) begin errors++; $display("FAIL areset_second got=%0d want=7", CDB_update_index); end
    tick();
    checks++; if (CDB_update_en !== 1'b0) begin errors++; $display("FAIL areset_discard got=%0b want=0", CDB_update_en); end
  endtask

  initial begin
    src_en       = '0;
    src_index    = '0;
    src_data     = '0;
    flush_signal = 1'b0;
    rdy_in       = 1'b1;
    rst_in       = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_overflow();
    test_flush();
    test_freeze();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter RoB_WIDTH, default 3, meaning the RoB index width carried on the CDB.
REQ-002 The block SHALL have parameter NUM_SRC, default 3, meaning the number of producers (0=RS ALU, 1=LSB, 2=spare/branch unit).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the per-source holding queue depth (power of two, >=2).
REQ-004 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous and active-low.
REQ-006 rdy_in  input  1  global enable; low freezes the block.
REQ-007 flush_signal  input  1  synchronous misprediction flush.
REQ-008 src_en  input  NUM_SRC  per-source result-valid strobe, one result per cycle per source.
REQ-009 src_index  input  NUM_SRC*RoB_WIDTH  per-source RoB entry, source i in bits [i*RoB_WIDTH +: RoB_WIDTH].
REQ-010 src_data  input  NUM_SRC*32  per-source result, source i in bits [i*32 +: 32].
REQ-011 src_full  output  NUM_SRC  per-source backpressure; producer SHALL NOT assert src_en[i] while src_full[i] is high.
REQ-012 CDB_update_en  output  1  registered broadcast valid.
REQ-013 CDB_update_index  output  RoB_WIDTH  registered broadcast RoB entry.
REQ-014 CDB_update_data  output  32  registered broadcast value.
REQ-015 overflow_err  output  1  sticky flag, set when a result is dropped.

Function
REQ-016 Each source SHALL own a FIFO of FIFO_DEPTH entries {index, data}; count[i] tracks occupancy 0..FIFO_DEPTH.
REQ-017 Candidate i SHALL be the FIFO head if count[i]>0, else the live input if src_en[i]=1, else none.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, first valid candidate wins; after any grant rr_ptr <= (grant+1) mod NUM_SRC; without a grant rr_ptr holds.
REQ-019 The winner SHALL be written to CDB_update_en/index/data at the edge; with no winner CDB_update_en <= 0 and index/data hold.
REQ-020 Latency SHALL be 1 cycle: src_en[i] at edge t with an empty FIFO and a grant -> CDB_update_en=1 after edge t (bypass, no FIFO write).
REQ-021 A live input that does not win SHALL be pushed into its FIFO at the same edge; a winning FIFO head SHALL be popped; simultaneous push and pop SHALL leave count unchanged.
REQ-022 FIFO order SHALL be preserved per source: a live input SHALL never bypass a non-empty FIFO of the same source.
REQ-023 src_full[i] SHALL be combinational, high when count[i] >= FIFO_DEPTH-1, so a producer seeing it low may issue exactly one more result.
REQ-024 src_en[i]=1 with count[i]=FIFO_DEPTH and no pop of source i SHALL drop that result and set overflow_err; FIFO contents unchanged.
REQ-025 flush_signal=1 (with rdy_in=1) SHALL empty all FIFOs, set CDB_update_en <= 0, reset rr_ptr to 0, ignore same-cycle src_en; overflow_err unchanged.
REQ-026 rdy_in=0 SHALL freeze every register, including CDB outputs, and ignore src_en and flush_signal.
REQ-027 At most one CDB broadcast SHALL occur per cycle; every accepted result SHALL be broadcast exactly once unless flushed.

Reset
REQ-028 rst_in low SHALL asynchronously set CDB_update_en=0, CDB_update_index=0, CDB_update_data=0, overflow_err=0, rr_ptr=0, all counts and FIFO pointers 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued results; the first grant after release SHALL go to source 0 if valid.

Structure
REQ-030 RoB_WIDTH, the NON_DEP encoding and the source-ID constants (SRC_RS, SRC_LSB, SRC_AUX) SHALL live in the shared CPU parameter package.
REQ-031 The per-source queue SHALL be one sub-module, cdb_src_fifo, instantiated NUM_SRC times via generate; arbitration and output register stay in cdb_arbiter.

Verification
REQ-032 Single: src_en[0]=1, index=3, data=0x0000_00AA, FIFOs empty -> next cycle CDB_update_en=1, index=3, data=0xAA; src_full stays 0.
REQ-033 Contention: all three sources valid at t (indices 1,2,4), rr_ptr=0 -> broadcasts index 1,2,4 on three consecutive cycles; rr_ptr ends at 0.
REQ-034 Fairness: source 0 and 1 valid every cycle for 8 cycles -> grants alternate 0,1,0,1; neither count exceeds FIFO_DEPTH; src_full honoured.
REQ-035 Overflow: force source 2 src_en while count=2 and it loses arbitration -> overflow_err=1, dropped result never appears on CDB.
REQ-036 Flush: two entries queued in source 1, flush_signal=1 -> next cycle CDB_update_en=0, all counts 0; later src_en[1], index=5 -> broadcast index 5.
REQ-037 Async reset: assert rst_in low between edges while CDB_update_en=1 -> outputs 0 immediately, before the next clk_in edge.
